width_downsizer: RTL
====================

// Module: width_downsizer
// PURPOSE
//  Reverse of the zero-extending width passthrough: splits each WIDTH_IN-bit word into
//  RATIO = WIDTH_IN/WIDTH_OUT narrow beats. Beats go out over a valid/ready stream.
//  Sits between a wide producer and a narrow consumer, e.g. a bus-to-serial-lane gearbox.
//  Full throughput: a new wide word is accepted in the same cycle its last beat leaves.
// PARAMETERS
//  WIDTH_IN   8  wide input word width; must be an integer multiple of WIDTH_OUT
//  WIDTH_OUT  4  narrow output beat width; WIDTH_OUT >= 1
// PORTS
//  clk       in   1          single clock, all logic on rising edge
//  rst_n     in   1          synchronous, active-low reset
//  s_data    in   WIDTH_IN   wide input word
//  s_valid   in   1          s_data valid
//  s_ready   out  1          block can accept s_data this cycle
//  m_data    out  WIDTH_OUT  narrow output beat
//  m_valid   out  1          m_data valid
//  m_ready   in   1          consumer accepts m_data this cycle
//  m_last    out  1          current beat is the final beat of its wide word
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE, beat cnt=0, hold reg=0.
//    Outputs after that edge: m_valid=0, m_data=0, m_last=0.
//    s_ready=0 whenever rst_n=0, including a reset asserted mid-word.
//    A mid-word reset discards the remaining beats; no partial word resumes.
//  - FSM states: IDLE (no word held) and SEND (word held, beat cnt in 0..RATIO-1).
//  - s_ready = rst_n & (IDLE | (SEND & m_ready & cnt==RATIO-1)).
//    This is combinational from state, cnt and m_ready; there is no path from s_valid.
//  - Input handshake: a word is accepted on an edge where s_valid & s_ready.
//    On acceptance: hold <= s_data, cnt <= 0, state <= SEND.
//    First beat is visible the following cycle (latency 1).
//  - In SEND: m_valid=1, m_data=slice(hold,cnt), m_last=(cnt==RATIO-1).
//  - Output handshake: beat transfers on an edge where m_valid & m_ready.
//    If cnt < RATIO-1, cnt increments.
//    If cnt == RATIO-1 and a new word is accepted on the same edge: reload, stay SEND.
//    If cnt == RATIO-1 and no new word: go to IDLE.
//  - Stall: while m_ready=0, m_data, m_last and cnt hold stable, and m_valid stays 1.
//    m_valid never drops without a transfer.
//  - RATIO==1: every beat has m_last=1; behaves as a one-deep registered pipe stage
//    that accepts a new word on each transfer.
//  - Illegal parameters (WIDTH_IN % WIDTH_OUT != 0, or WIDTH_OUT > WIDTH_IN):
//    elaboration-time $error.
//  - cnt width is $clog2(RATIO), with a minimum of 1 bit.
// CONFIGURATION
//  - Macro WIDTH_DOWNSIZER_MSB_FIRST_EN.
//  - Defined: beat k = hold[WIDTH_IN-1-k*WIDTH_OUT -: WIDTH_OUT] (most significant slice first).
//  - Undefined (default): beat k = hold[k*WIDTH_OUT +: WIDTH_OUT] (least significant slice first).
//  - Handshake timing, reset and m_last are identical in both builds.
// STRUCTURE
//  - Package width_conv_pkg holds:
//    - typedef enum logic {IDLE, SEND} wconv_state_e
//    - function automatic int wconv_ratio(int win, int wout)
//    - function automatic int wconv_cnt_w(int ratio), returning max(1, $clog2(ratio))
//  - Single module; no sub-module. The slice mux is an inline function.
// TESTING
//  Defaults: WIDTH_IN=8, WIDTH_OUT=4, LSB-first build unless stated.
//  1 Reset: hold rst_n=0 for 3 clk with s_valid=1.
//    -> s_ready=0, m_valid=0, m_data=0x0, m_last=0 throughout.
//  2 Single word: send 0xA5 with m_ready=1.
//    -> beats 0x5 then 0xA on consecutive cycles; m_last=0 then 1;
//       first beat 1 cycle after acceptance.
//  3 Back-to-back: s_valid held, words 0x12, 0x34, 0x56, m_ready=1.
//    -> beats 2,1,4,3,6,5 with no bubbles; s_ready high only on the last beat of each word.
//  4 Backpressure: m_ready=0 for 4 cycles mid-word 0xC3.
//    -> m_data=0xC, m_last=1 and m_valid=1 stable; s_ready=0; output resumes on m_ready=1.
//  5 Mid-word reset: after beat 0x3 of 0x93 transfers, pulse rst_n=0.
//    -> m_valid=0 the next cycle; the next word 0x7E emits 0xE, 0x7.
//  6 MSB-first build, WIDTH_IN=12, WIDTH_OUT=4, word 0xABC.
//    -> beats 0xA, 0xB, 0xC, m_last on 0xC.
//    Also with WIDTH_IN=WIDTH_OUT=4: every beat has m_last=1.

Source files
------------

// File: rtl/width_conv_pkg.sv
// width_conv_pkg: shared types and sizing helpers for the width converters.
//   wconv_state_e - IDLE (no word held) / SEND (word held, beats going out)
//   wconv_ratio   - number of narrow beats per wide word (0 if the widths are unusable)
//   wconv_cnt_w   - beat counter width, never less than one bit
package width_conv_pkg;

    typedef enum logic {IDLE, SEND} wconv_state_e;

    function automatic int wconv_ratio(int win, int wout);
        return (wout > 0) ? win / wout : 0;
    endfunction

    function automatic int wconv_cnt_w(int ratio);
        return ($clog2(ratio) > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/width_downsizer.sv
// width_downsizer: splits each WIDTH_IN-bit word into WIDTH_IN/WIDTH_OUT narrow beats.
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   s_data   in   wide input word
//   s_valid  in   s_data valid
//   s_ready  out  word can be accepted this cycle (never depends on s_valid)
//   m_data   out  narrow output beat
//   m_valid  out  m_data valid
//   m_ready  in   consumer takes m_data this cycle
//   m_last   out  final beat of the current word
// Build option WIDTH_DOWNSIZER_MSB_FIRST_EN sends the most significant slice first;
// by default the least significant slice goes first.
module width_downsizer
    import width_conv_pkg::*;
#(
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_OUT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH_IN-1:0]  s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [WIDTH_OUT-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last
);

    localparam int RATIO = wconv_ratio(WIDTH_IN, WIDTH_OUT);
    localparam int CW    = wconv_cnt_w(RATIO);

    if (WIDTH_OUT < 1 || WIDTH_OUT > WIDTH_IN || (WIDTH_IN % WIDTH_OUT) != 0) begin : g_bad_params
        $error("width_downsizer: WIDTH_IN (%0d) must be a positive multiple of WIDTH_OUT (%0d)",
               WIDTH_IN, WIDTH_OUT);
    end

    wconv_state_e         state, state_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [WIDTH_IN-1:0]  hold, hold_nx;
    logic                 last, accept, xfer;

    function automatic logic [WIDTH_OUT-1:0] slice(input logic [WIDTH_IN-1:0] w,
                                                   input logic [CW-1:0] k);
`ifdef WIDTH_DOWNSIZER_MSB_FIRST_EN
        return WIDTH_OUT'(w >> (WIDTH_IN - (int'(k) + 1) * WIDTH_OUT));
`else
        return WIDTH_OUT'(w >> (int'(k) * WIDTH_OUT));
`endif
    endfunction

    assign last    = (cnt == CW'(RATIO - 1));
    // A new word may enter while the final beat of the held word is leaving.
    assign s_ready = rst_n & ((state == IDLE) | ((state == SEND) & m_ready & last));
    assign accept  = s_valid & s_ready;
    assign m_valid = (state == SEND);
    assign xfer    = m_valid & m_ready;
    assign m_data  = m_valid ? slice(hold, cnt) : '0;
    assign m_last  = m_valid & last;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        hold_nx  = hold;
        if (accept) begin
            state_nx = SEND;
            cnt_nx   = '0;
            hold_nx  = s_data;
        end else if (xfer) begin
            state_nx = last ? IDLE : SEND;
            cnt_nx   = last ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hold  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            hold  <= hold_nx;
        end
    end

endmodule
